// File: rtl/tybec_axis_fork_tx_if.sv
// rtl/tybec_axis_fork_tx_if.sv - main result stream in, C_NUM_CHANNELS AXIS masters out.
// Optional TY_AXIS_TLAST_EN adds cfg_nbeats and m_tlast.
interface tybec_axis_fork_tx_if #(
    parameter int C_DATA_WIDTH   = 256,
    parameter int C_NUM_CHANNELS = 2
);
    logic                                         ivalid;
    logic [C_DATA_WIDTH-1:0]                      idata;
    logic                                         iready;
    logic [C_NUM_CHANNELS-1:0]                    m_tvalid;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  m_tdata;
    logic [C_NUM_CHANNELS-1:0]                    m_tready;
`ifdef TY_AXIS_TLAST_EN
    logic [31:0]                                  cfg_nbeats;
    logic [C_NUM_CHANNELS-1:0]                    m_tlast;

    modport master (
        input  ivalid, idata, m_tready, cfg_nbeats,
        output iready, m_tvalid, m_tdata, m_tlast
    );
    modport slave (
        output ivalid, idata, m_tready, cfg_nbeats,
        input  iready, m_tvalid, m_tdata, m_tlast
    );
`else
    modport master (
        input  ivalid, idata, m_tready,
        output iready, m_tvalid, m_tdata
    );
    modport slave (
        output ivalid, idata, m_tready,
        input  iready, m_tvalid, m_tdata
    );
`endif
endinterface

// File: rtl/tybec_axis_fork_tx.sv
// rtl/tybec_axis_fork_tx.sv - broadcast FIFO feeding independent AXIS channels; word retires when all accept.
// Optional packet framing (m_tlast, cfg_nbeats) under macro TY_AXIS_TLAST_EN.
module tybec_axis_fork_tx #(
    parameter int C_DATA_WIDTH   = 256,
    parameter int C_NUM_CHANNELS = 2,
    parameter int C_FIFO_DEPTH   = 2
) (
    input  logic                  aclk,
    input  logic                  areset,
    tybec_axis_fork_tx_if.master  bus
);
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(C_FIFO_DEPTH);

    logic [C_DATA_WIDTH-1:0]   mem [C_FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [AW:0]               count;
    logic [AW:0]               count_nxt;
    logic [C_NUM_CHANNELS-1:0] sent;
    logic [C_NUM_CHANNELS-1:0] tvalid;
    logic [C_NUM_CHANNELS-1:0] hs;
    logic                      iready_q;
    logic                      empty;
    logic                      push;
    logic                      pop;

    // A channel that already took the head counts as accepted until the word retires.
    always_comb begin
        empty     = (count == '0);
        tvalid    = empty ? '0 : ~sent;
        hs        = tvalid & bus.m_tready;
        push      = bus.ivalid & iready_q;
        pop       = ~empty & (&(sent | hs));
        count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            sent     <= '0;
            iready_q <= 1'b0;
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.idata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                sent   <= '0;
            end else begin
                sent   <= sent | hs;
            end
            count    <= count_nxt;
            iready_q <= (count_nxt < FULL_CNT);
        end
    end

    assign bus.iready   = iready_q;
    assign bus.m_tvalid = tvalid;
    assign bus.m_tdata  = {C_NUM_CHANNELS{mem[rd_ptr]}};

`ifdef TY_AXIS_TLAST_EN
    logic [31:0] beat_cnt;
    logic [31:0] nbeats_q;
    logic [31:0] nbeats_eff;
    logic        last_beat;

    // Packet length is taken live on the first beat, then held for the rest of the packet.
    always_comb begin
        nbeats_eff = (beat_cnt == '0) ? bus.cfg_nbeats : nbeats_q;
        last_beat  = (nbeats_eff != '0) && (beat_cnt == nbeats_eff - 32'd1);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_cnt <= '0;
            nbeats_q <= '0;
        end else begin
            if (beat_cnt == '0) begin
                nbeats_q <= bus.cfg_nbeats;
            end
            if (pop) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 32'd1;
            end
        end
    end

    assign bus.m_tlast = tvalid & {C_NUM_CHANNELS{last_beat}};
`endif
endmodule

// File: tb/tb_tybec_axis_fork_tx.sv
// tb/tb_tybec_axis_fork_tx.sv - directed bench for tybec_axis_fork_tx (m_tlast checks when TY_AXIS_TLAST_EN).
module tb_tybec_axis_fork_tx;
    localparam int DW    = 256;
    localparam int NC    = 2;
    localparam int DEPTH = 2;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    tybec_axis_fork_tx_if #(.C_DATA_WIDTH(DW), .C_NUM_CHANNELS(NC)) bus ();

    tybec_axis_fork_tx #(
        .C_DATA_WIDTH   (DW),
        .C_NUM_CHANNELS (NC),
        .C_FIFO_DEPTH   (DEPTH)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int n_push = 0;
    logic [DW-1:0] rxq [NC][$];
    logic          tlq [NC][$];

    // Records what the coming edge will transfer, then advances one cycle.
    task automatic tick();
        for (int i = 0; i < NC; i++) begin
            if (bus.m_tvalid[i] && bus.m_tready[i]) begin
                rxq[i].push_back(bus.m_tdata[i]);
`ifdef TY_AXIS_TLAST_EN
                tlq[i].push_back(bus.m_tlast[i]);
`endif
            end
        end
        if (bus.ivalid && bus.iready) n_push++;
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_rx();
        for (int i = 0; i < NC; i++) begin
            rxq[i].delete();
            tlq[i].delete();
        end
        n_push = 0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        bus.ivalid = 1'b0;
        bus.idata = '0;
        bus.m_tready = '0;
        repeat (3) tick();
        n_vec++; if (bus.iready !== 1'b0) begin n_fail++; $display("FAIL reset_iready got %b exp 0", bus.iready); end
        n_vec++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL reset_tvalid got %b exp 00", bus.m_tvalid); end
        n_vec++; if (bus.m_tdata[0] !== '0) begin n_fail++; $display("FAIL reset_tdata got %h exp 0", bus.m_tdata[0]); end
        areset = 1'b0;
        tick();
        n_vec++; if (bus.iready !== 1'b1) begin n_fail++; $display("FAIL reset_release_iready got %b exp 1", bus.iready); end
    endtask

    task automatic test_throughput();
        logic dropped;
        logic [DW-1:0] exp_w;
        dropped = 1'b0;
        clear_rx();
        bus.m_tready = 2'b11;
        for (int c = 0; c < 16; c++) begin
            bus.ivalid = 1'b1;
            bus.idata = DW'(n_push + 1);
            if (bus.iready !== 1'b1) dropped = 1'b1;
            tick();
            if (c == 0) begin
                n_vec++; if (bus.m_tvalid !== 2'b11) begin n_fail++; $display("FAIL tput_first_tvalid got %b exp 11", bus.m_tvalid); end
                n_vec++; if (bus.m_tdata[1] !== DW'(1)) begin n_fail++; $display("FAIL tput_first_tdata got %h exp 1", bus.m_tdata[1]); end
            end
        end
        bus.ivalid = 1'b0;
        n_vec++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL tput_iready_drop got %b exp 0", dropped); end
        n_vec++; if (rxq[0].size() != 15) begin n_fail++; $display("FAIL tput_rate got %0d exp 15", rxq[0].size()); end
        repeat (3) tick();
        for (int ch = 0; ch < NC; ch++) begin
            n_vec++; if (rxq[ch].size() != 16) begin n_fail++; $display("FAIL tput_count ch%0d got %0d exp 16", ch, rxq[ch].size()); end
            for (int j = 0; j < rxq[ch].size(); j++) begin
                exp_w = DW'(j + 1);
                n_vec++; if (rxq[ch][j] !== exp_w) begin n_fail++; $display("FAIL tput_data ch%0d[%0d] got %h exp %h", ch, j, rxq[ch][j], exp_w); end
            end
        end
    endtask

    task automatic test_skewed_ready();
        logic [DW-1:0] exp_w;
        clear_rx();
        for (int c = 0; c < 15; c++) begin
            bus.m_tready = (c < 5) ? 2'b01 : 2'b11;
            bus.ivalid = (n_push < 3);
            bus.idata = DW'(8'hA0 + n_push);
            if (c == 4) begin
                n_vec++; if (bus.iready !== 1'b0) begin n_fail++; $display("FAIL skew_full_iready got %b exp 0", bus.iready); end
                n_vec++; if (bus.m_tvalid !== 2'b10) begin n_fail++; $display("FAIL skew_tvalid got %b exp 10", bus.m_tvalid); end
                n_vec++; if (bus.m_tdata[1] !== DW'(8'hA0)) begin n_fail++; $display("FAIL skew_hold_data got %h exp a0", bus.m_tdata[1]); end
            end
            tick();
            if (c == 4) begin
                n_vec++; if (rxq[0].size() != 1) begin n_fail++; $display("FAIL skew_ch0_once got %0d exp 1", rxq[0].size()); end
                n_vec++; if (rxq[1].size() != 0) begin n_fail++; $display("FAIL skew_ch1_wait got %0d exp 0", rxq[1].size()); end
            end
        end
        bus.ivalid = 1'b0;
        for (int ch = 0; ch < NC; ch++) begin
            n_vec++; if (rxq[ch].size() != 3) begin n_fail++; $display("FAIL skew_count ch%0d got %0d exp 3", ch, rxq[ch].size()); end
            for (int j = 0; j < rxq[ch].size(); j++) begin
                exp_w = DW'(8'hA0 + j);
                n_vec++; if (rxq[ch][j] !== exp_w) begin n_fail++; $display("FAIL skew_data ch%0d[%0d] got %h exp %h", ch, j, rxq[ch][j], exp_w); end
            end
        end
    endtask

    task automatic test_full();
        logic [DW-1:0] exp_w;
        clear_rx();
        bus.m_tready = 2'b00;
        for (int c = 0; c < 6; c++) begin
            bus.ivalid = 1'b1;
            bus.idata = DW'(8'hC0 + n_push);
            tick();
        end
        n_vec++; if (n_push != DEPTH) begin n_fail++; $display("FAIL full_accepted got %0d exp %0d", n_push, DEPTH); end
        n_vec++; if (bus.iready !== 1'b0) begin n_fail++; $display("FAIL full_iready got %b exp 0", bus.iready); end
        n_vec++; if (bus.m_tdata[0] !== DW'(8'hC0)) begin n_fail++; $display("FAIL full_tdata got %h exp c0", bus.m_tdata[0]); end
        n_vec++; if (bus.m_tvalid !== 2'b11) begin n_fail++; $display("FAIL full_tvalid got %b exp 11", bus.m_tvalid); end
        bus.m_tready = 2'b11;
        for (int c = 0; c < 14; c++) begin
            bus.ivalid = (n_push < 6);
            bus.idata = DW'(8'hC0 + n_push);
            tick();
        end
        bus.ivalid = 1'b0;
        for (int ch = 0; ch < NC; ch++) begin
            n_vec++; if (rxq[ch].size() != 6) begin n_fail++; $display("FAIL full_count ch%0d got %0d exp 6", ch, rxq[ch].size()); end
            for (int j = 0; j < rxq[ch].size(); j++) begin
                exp_w = DW'(8'hC0 + j);
                n_vec++; if (rxq[ch][j] !== exp_w) begin n_fail++; $display("FAIL full_data ch%0d[%0d] got %h exp %h", ch, j, rxq[ch][j], exp_w); end
            end
        end
    endtask

    task automatic test_same_edge();
        clear_rx();
        bus.m_tready = 2'b11;
        bus.ivalid = 1'b1;
        bus.idata = DW'(8'hD0);
        tick();
        bus.idata = DW'(8'hD1);
        tick();
        bus.ivalid = 1'b0;
        n_vec++; if (bus.m_tvalid !== 2'b11) begin n_fail++; $display("FAIL same_tvalid got %b exp 11", bus.m_tvalid); end
        n_vec++; if (bus.m_tdata[0] !== DW'(8'hD1)) begin n_fail++; $display("FAIL same_tdata0 got %h exp d1", bus.m_tdata[0]); end
        n_vec++; if (bus.m_tdata[1] !== DW'(8'hD1)) begin n_fail++; $display("FAIL same_tdata1 got %h exp d1", bus.m_tdata[1]); end
        n_vec++; if (bus.iready !== 1'b1) begin n_fail++; $display("FAIL same_iready got %b exp 1", bus.iready); end
        n_vec++; if (rxq[1].size() != 1) begin n_fail++; $display("FAIL same_first got %0d exp 1", rxq[1].size()); end
        tick();
        n_vec++; if (rxq[0].size() != 2) begin n_fail++; $display("FAIL same_total got %0d exp 2", rxq[0].size()); end
        n_vec++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL same_drained got %b exp 00", bus.m_tvalid); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] exp_w;
        clear_rx();
        bus.m_tready = 2'b01;
        bus.ivalid = 1'b1;
        bus.idata = DW'(8'hB0);
        tick();
        bus.idata = DW'(8'hB1);
        tick();
        bus.ivalid = 1'b0;
        n_vec++; if (bus.m_tvalid !== 2'b10) begin n_fail++; $display("FAIL mid_pre_tvalid got %b exp 10", bus.m_tvalid); end
        areset = 1'b1;
        tick();
        n_vec++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL mid_tvalid got %b exp 00", bus.m_tvalid); end
        n_vec++; if (bus.iready !== 1'b0) begin n_fail++; $display("FAIL mid_iready got %b exp 0", bus.iready); end
        areset = 1'b0;
        tick();
        n_vec++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL mid_stale got %b exp 00", bus.m_tvalid); end
        clear_rx();
        bus.m_tready = 2'b11;
        for (int c = 0; c < 6; c++) begin
            bus.ivalid = (n_push < 2);
            bus.idata = DW'(8'hE0 + n_push);
            tick();
        end
        bus.ivalid = 1'b0;
        for (int ch = 0; ch < NC; ch++) begin
            n_vec++; if (rxq[ch].size() != 2) begin n_fail++; $display("FAIL mid_count ch%0d got %0d exp 2", ch, rxq[ch].size()); end
            for (int j = 0; j < rxq[ch].size(); j++) begin
                exp_w = DW'(8'hE0 + j);
                n_vec++; if (rxq[ch][j] !== exp_w) begin n_fail++; $display("FAIL mid_data ch%0d[%0d] got %h exp %h", ch, j, rxq[ch][j], exp_w); end
            end
        end
    endtask

`ifdef TY_AXIS_TLAST_EN
    task automatic test_tlast();
        logic exp_l;
        for (int pass = 0; pass < 2; pass++) begin
            clear_rx();
            bus.cfg_nbeats = (pass == 0) ? 32'd4 : 32'd0;
            bus.m_tready = 2'b11;
            for (int c = 0; c < 12; c++) begin
                bus.ivalid = (n_push < 8);
                bus.idata = DW'(8'hF0 + n_push);
                tick();
            end
            bus.ivalid = 1'b0;
            for (int ch = 0; ch < NC; ch++) begin
                n_vec++; if (tlq[ch].size() != 8) begin n_fail++; $display("FAIL tlast_count p%0d ch%0d got %0d exp 8", pass, ch, tlq[ch].size()); end
                for (int j = 0; j < tlq[ch].size(); j++) begin
                    exp_l = (pass == 0) && ((j % 4) == 3);
                    n_vec++; if (tlq[ch][j] !== exp_l) begin n_fail++; $display("FAIL tlast p%0d ch%0d[%0d] got %b exp %b", pass, ch, j, tlq[ch][j], exp_l); end
                end
            end
        end
    endtask
`endif

    initial begin
        areset = 1'b1;
        bus.ivalid = 1'b0;
        bus.idata = '0;
        bus.m_tready = '0;
`ifdef TY_AXIS_TLAST_EN
        bus.cfg_nbeats = '0;
`endif
        #1;
        test_reset();
        test_throughput();
        test_skewed_ready();
        test_full();
        test_same_edge();
        test_reset_mid();
`ifdef TY_AXIS_TLAST_EN
        test_tlast();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
